// File: rtl/wb_fir_pkg.sv
// wb_fir_pkg: shared definitions for the Wishbone FIR controller.
// Holds the register offsets within the user window, the ap_ctrl bit
// positions, the controller FSM state type and a helper that packs the
// ap_ctrl status word.
package wb_fir_pkg;

  localparam logic [7:0] OFF_AP_CTRL  = 8'h00;
  localparam logic [7:0] OFF_DATA_LEN = 8'h10;
  localparam logic [7:0] OFF_X_PORT   = 8'h80;
  localparam logic [7:0] OFF_Y_PORT   = 8'h84;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fir_state_t;

  // ap_start always reads back as 0, so only done/idle are packed.
  function automatic logic [31:0] ap_ctrl_word(input logic idle, input logic done);
    logic [31:0] v;
    v = '0;
    v[AP_DONE_BIT] = done;
    v[AP_IDLE_BIT] = idle;
    return v;
  endfunction

endpackage

// File: rtl/wb_fir_ctrl_stream_buf.sv
// wb_stream_buf: one-entry valid/ready holding buffer.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_s_data/i_s_valid/o_s_ready  upstream side (o_s_ready = buffer empty)
//   o_m_data/o_m_valid/i_m_ready  downstream side (o_m_valid = buffer full)
// The held word stays stable while the entry waits for i_m_ready.
module wb_stream_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;

  // A single entry cannot load and drain in the same cycle: loading
  // requires empty, draining requires full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (r_full) begin
      if (i_m_ready) r_full <= 1'b0;
    end else if (i_s_valid) begin
      r_full <= 1'b1;
      r_data <= i_s_data;
    end
  end

  assign o_s_ready = ~r_full;
  assign o_m_valid = r_full;
  assign o_m_data  = r_data;

endmodule

// File: rtl/wb_fir_ctrl.sv
// wb_fir_ctrl: Wishbone slave that sequences the user-area FIR datapath.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wbs_*                 Wishbone classic slave (registered one-cycle ack)
//   ap_start_o            one-cycle start pulse to the datapath
//   cfg_len_o             sample count for the current run
//   x_tdata/tvalid/tready input sample stream towards the datapath
//   y_tdata/tvalid/tready output sample stream from the datapath
// Register window (offset): 0x00 ap_ctrl, 0x10 data_length, 0x80 x port,
// 0x84 y port; other offsets ack, read 0, ignore writes.
// Stream back-pressure is applied by withholding ack.
//
// state | meaning
// IDLE  | waiting for ap_start; length writable; x writes dropped
// RUN   | streaming; ends when y count equals length
module wb_fir_ctrl
  import wb_fir_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
  output logic                ap_start_o,
  output logic [DATA_W-1:0]   cfg_len_o,
  output logic [DATA_W-1:0]   x_tdata_o,
  output logic                x_tvalid_o,
  input  logic                x_tready_i,
  input  logic [DATA_W-1:0]   y_tdata_i,
  input  logic                y_tvalid_i,
  output logic                y_tready_o
);

  fir_state_t r_state, w_state_nxt;

  logic              r_ack, r_hold, r_ap_start, r_done;
  logic [DATA_W-1:0] r_dat, r_len, r_x_cnt, r_y_cnt;

  logic [ADDR_W-1:0] w_off;
  logic w_req, w_serve, w_full_lanes, w_run;
  logic w_sel_ctrl, w_sel_len, w_sel_x, w_sel_y;
  logic w_x_wr, w_x_live, w_x_stall, w_x_push, w_x_s_ready;
  logic w_y_rd, w_y_stall, w_y_pop, w_y_bypass, w_y_fire, w_y_full;
  logic w_ack_nxt, w_start_wr, w_len_wr, w_ctrl_rd;
  logic w_ap_start_nxt, w_done_set, w_clr_cnt;
  logic [DATA_W-1:0] w_y_buf_data, w_rdata, w_y_cnt_inc;

  // Window check assumes BASE_ADDR is aligned to 2^ADDR_W.
  assign w_off   = wbs_adr_i[ADDR_W-1:0];
  assign w_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
  // r_hold blocks a still-held request from being acked a second time.
  assign w_serve = w_req & ~r_hold;
  assign w_run   = (r_state == ST_RUN);

  assign w_full_lanes = &wbs_sel_i;
  assign w_sel_ctrl   = (w_off == ADDR_W'(OFF_AP_CTRL));
  assign w_sel_len    = (w_off == ADDR_W'(OFF_DATA_LEN));
  assign w_sel_x      = (w_off == ADDR_W'(OFF_X_PORT));
  assign w_sel_y      = (w_off == ADDR_W'(OFF_Y_PORT));

  assign w_x_wr    = w_serve & wbs_we_i & w_sel_x & w_full_lanes;
  assign w_x_live  = w_run & (r_x_cnt != r_len);
  assign w_x_stall = w_x_wr & w_x_live & ~w_x_s_ready;

  // An empty y read stalls only in RUN, and not when a sample arrives
  // this very cycle (that sample is forwarded straight to the bus).
  assign w_y_rd    = w_serve & ~wbs_we_i & w_sel_y & w_full_lanes;
  assign w_y_stall = w_y_rd & w_run & ~w_y_full & ~y_tvalid_i;

  assign w_ack_nxt  = w_serve & ~w_x_stall & ~w_y_stall;
  assign w_x_push   = w_ack_nxt & w_x_wr & w_x_live;
  assign w_y_pop    = w_ack_nxt & w_y_rd & w_y_full;
  assign w_y_bypass = w_ack_nxt & w_y_rd & ~w_y_full & y_tvalid_i;
  assign w_y_fire   = y_tvalid_i & y_tready_o & w_run;

  assign w_start_wr = w_ack_nxt & wbs_we_i & w_sel_ctrl & wbs_sel_i[0] & wbs_dat_i[AP_START_BIT];
  assign w_len_wr   = w_ack_nxt & wbs_we_i & w_sel_len & ~w_run;
  assign w_ctrl_rd  = w_ack_nxt & ~wbs_we_i & w_sel_ctrl;

  assign w_y_cnt_inc = r_y_cnt + 1'b1;

  always_comb begin
    w_rdata = '0;
    if (!wbs_we_i) begin
      if (w_sel_ctrl)
        w_rdata = DATA_W'(ap_ctrl_word(~w_run, r_done));
      else if (w_sel_len)
        w_rdata = r_len;
      else if (w_sel_y && w_full_lanes)
        w_rdata = w_y_full ? w_y_buf_data : (y_tvalid_i ? y_tdata_i : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ap_start_nxt = 1'b0;
    w_done_set     = 1'b0;
    w_clr_cnt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_wr) begin
          if (r_len != '0) begin
            w_state_nxt    = ST_RUN;
            w_ap_start_nxt = 1'b1;
            w_clr_cnt      = 1'b1;
          end else begin
            w_done_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_y_fire && (w_y_cnt_inc == r_len)) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_hold     <= 1'b0;
      r_ap_start <= 1'b0;
      r_done     <= 1'b0;
      r_len      <= '0;
      r_x_cnt    <= '0;
      r_y_cnt    <= '0;
    end else begin
      r_ack      <= w_ack_nxt;
      r_dat      <= w_ack_nxt ? w_rdata : '0;
      r_hold     <= w_req & (r_hold | w_ack_nxt);
      r_ap_start <= w_ap_start_nxt;
      if (w_len_wr) begin
        for (int b = 0; b < DATA_W/8; b++)
          if (wbs_sel_i[b]) r_len[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
      if (w_clr_cnt) begin
        r_x_cnt <= '0;
        r_y_cnt <= '0;
      end else begin
        if (w_x_push) r_x_cnt <= r_x_cnt + 1'b1;
        if (w_y_fire) r_y_cnt <= w_y_cnt_inc;
      end
      // A done event in the same cycle as a status read wins over the clear.
      if (w_clr_cnt || w_ctrl_rd) r_done <= 1'b0;
      if (w_done_set)             r_done <= 1'b1;
    end
  end

  wb_stream_buf #(.DATA_W(DATA_W)) u_x_buf (
    .clk       (clk),
    .rst       (rst),
    .i_s_data  (wbs_dat_i),
    .i_s_valid (w_x_push),
    .o_s_ready (w_x_s_ready),
    .o_m_data  (x_tdata_o),
    .o_m_valid (x_tvalid_o),
    .i_m_ready (x_tready_i)
  );

  // A forwarded sample is handed to the bus directly and never stored.
  wb_stream_buf #(.DATA_W(DATA_W)) u_y_buf (
    .clk       (clk),
    .rst       (rst),
    .i_s_data  (y_tdata_i),
    .i_s_valid (y_tvalid_i & ~w_y_bypass),
    .o_s_ready (y_tready_o),
    .o_m_data  (w_y_buf_data),
    .o_m_valid (w_y_full),
    .i_m_ready (w_y_pop)
  );

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign ap_start_o = r_ap_start;
  assign cfg_len_o  = r_len;

endmodule

// File: tb/tb_wb_fir_ctrl.sv
module tb_wb_fir_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        ap_start;
  logic [31:0] cfg_len;
  logic [31:0] x_tdata;
  logic        x_tvalid;
  logic        x_tready = 1'b1;
  logic [31:0] y_tdata = '0;
  logic        y_tvalid = 1'b0;
  logic        y_tready;

  int n_checks = 0;
  int n_errors = 0;
  int start_hi = 0;
  int x_xfers  = 0;

  logic [31:0] x_exp[$];
  logic [31:0] y_exp[$];

  always #5 clk = ~clk;

  wb_fir_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .ap_start_o (ap_start),
    .cfg_len_o  (cfg_len),
    .x_tdata_o  (x_tdata),
    .x_tvalid_o (x_tvalid),
    .x_tready_i (x_tready),
    .y_tdata_i  (y_tdata),
    .y_tvalid_i (y_tvalid),
    .y_tready_o (y_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + {24'h0, off}; wdat = d; sel = s;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i;
        rd  = rdat;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", {31'b0, ack}, 32'h0);
  endtask

  task automatic y_send(input logic [31:0] v);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    y_tvalid = 1'b1; y_tdata = v;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (y_tready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("y_send_handshake", {31'b0, ok}, 32'h1);
    if (ok) y_exp.push_back(v);
    @(posedge clk); #1;
    y_tvalid = 1'b0;
  endtask

  task automatic y_read_check(input string name);
    logic [31:0] rd;
    logic [31:0] e;
    int lat;
    wb_xfer(1'b0, 8'h84, 32'h0, 4'hF, rd, lat);
    chk({name, "_acked"}, {31'b0, lat >= 1}, 32'h1);
    if (y_exp.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_sb_empty got=%0h want=none", name, rd);
    end else begin
      e = y_exp.pop_front();
      chk({name, "_data"}, rd, e);
    end
  endtask

  // x stream monitor: order via scoreboard, stability while stalled.
  logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [31:0] pd = '0;
  always @(negedge clk) begin
    if (!rst && x_tvalid && x_tready) begin
      x_xfers++;
      if (x_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL x_unexpected got=%0h want=none", x_tdata);
      end else begin
        chk("x_order", x_tdata, x_exp.pop_front());
      end
    end
    if (pv && !pr && !prst && !rst) begin
      chk("x_valid_held", {31'b0, x_tvalid}, 32'h1);
      chk("x_data_stable", x_tdata, pd);
    end
    pv = x_tvalid; pr = x_tready; pd = x_tdata; prst = rst;
  end

  always @(negedge clk) if (ap_start) start_hi++;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        w;
    logic [7:0]  off;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  initial begin
    logic [31:0] rd;
    int lat, lat3, n, sh0;

    vt[0]  = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h4};
    vt[1]  = '{1'b1, 8'h10, 32'h4,         4'hF, 32'h0};
    vt[2]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h4};
    vt[3]  = '{1'b1, 8'h10, 32'hAABBCCDD,  4'h5, 32'h0};
    vt[4]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h00BB00DD};
    vt[5]  = '{1'b1, 8'h10, 32'h4,         4'hF, 32'h0};
    vt[6]  = '{1'b1, 8'h20, 32'd123,       4'hF, 32'h0};
    vt[7]  = '{1'b0, 8'h20, 32'h0,         4'hF, 32'h0};
    vt[8]  = '{1'b0, 8'h84, 32'h0,         4'hF, 32'h0};
    vt[9]  = '{1'b1, 8'h80, 32'h55,        4'hF, 32'h0};
    vt[10] = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h4};
    vt[11] = '{1'b1, 8'h00, 32'h1,         4'hE, 32'h0};
    vt[12] = '{1'b1, 8'h00, 32'h0,         4'hF, 32'h0};
    vt[13] = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h4};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_ap_start", {31'b0, ap_start}, 32'h0);
    chk("rst_cfg_len", cfg_len, 32'h0);
    chk("rst_x_tvalid", {31'b0, x_tvalid}, 32'h0);
    chk("rst_x_tdata", x_tdata, 32'h0);
    chk("rst_y_tready", {31'b0, y_tready}, 32'h1);

    // register map in IDLE
    for (int i = 0; i < NV; i++) begin
      wb_xfer(vt[i].w, vt[i].off, vt[i].d, vt[i].s, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, 32'd1);
      if (!vt[i].w) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
    end
    chk("cfg_len_out", cfg_len, 32'h4);
    chk("no_start_yet", start_hi, 32'd0);

    // held request acked once; outside window never acked
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    n = 0;
    repeat (6) begin @(negedge clk); if (ack) n++; end
    @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
    chk("held_req_acks", n, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h100;
    n = 0;
    repeat (5) begin @(negedge clk); if (ack) n++; end
    @(posedge clk); #1; adr = BASE - 32'h4;
    repeat (5) begin @(negedge clk); if (ack) n++; end
    @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
    chk("out_of_window_acks", n, 32'd0);

    // start run of 4
    sh0 = start_hi;
    wb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, lat);
    repeat (2) @(negedge clk);
    chk("start_pulse_cycles", start_hi - sh0, 32'd1);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    chk("run_status", rd, 32'h0);

    // x stream with a stall on the second sample
    x_exp.push_back(32'd1);
    wb_xfer(1'b1, 8'h80, 32'd1, 4'hF, rd, lat);
    chk("x1_lat", lat, 32'd1);
    @(posedge clk); #1; x_tready = 1'b0;
    x_exp.push_back(32'd2);
    wb_xfer(1'b1, 8'h80, 32'd2, 4'hF, rd, lat);
    chk("x2_lat", lat, 32'd1);
    chk("x2_valid", {31'b0, x_tvalid}, 32'h1);
    fork
      begin
        x_exp.push_back(32'd3);
        wb_xfer(1'b1, 8'h80, 32'd3, 4'hF, rd, lat3);
      end
      begin
        repeat (5) @(posedge clk);
        #1 x_tready = 1'b1;
      end
    join
    chk("x3_backpressure_lat", lat3, 32'd6);
    x_exp.push_back(32'd4);
    wb_xfer(1'b1, 8'h80, 32'd4, 4'hF, rd, lat);
    chk("x4_lat", lat, 32'd1);
    wb_xfer(1'b1, 8'h80, 32'd99, 4'hF, rd, lat);
    chk("x_extra_lat", lat, 32'd1);
    repeat (3) @(negedge clk);
    chk("x_xfers", x_xfers, 32'd4);
    chk("x_sb_drained", x_exp.size(), 32'd0);

    // y stream through the 1-entry holding register
    fork
      begin
        y_send(32'd10); y_send(32'd20); y_send(32'd30); y_send(32'd40);
      end
      begin
        for (int k = 0; k < 4; k++) y_read_check($sformatf("y%0d", k));
      end
    join
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    chk("done_status", rd, 32'h6);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    chk("done_cleared", rd, 32'h4);

    // y read waiting in RUN, sample arrives while the read is pending
    wb_xfer(1'b1, 8'h10, 32'h1, 4'hF, rd, lat);
    wb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, lat);
    fork
      begin
        wb_xfer(1'b0, 8'h84, 32'h0, 4'hF, rd, lat);
      end
      begin
        @(posedge clk); #1;
        n = 0;
        repeat (6) begin @(negedge clk); if (ack) n++; end
        @(posedge clk); #1;
        y_tvalid = 1'b1; y_tdata = 32'd77;
        y_exp.push_back(32'd77);
        @(posedge clk); #1;
        y_tvalid = 1'b0;
      end
    join
    chk("y_wait_no_ack", n, 32'd0);
    chk("y_wait_lat", lat, 32'd7);
    chk("y_wait_data", rd, y_exp.pop_front());
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    chk("len1_done", rd, 32'h6);

    // zero-length start
    wb_xfer(1'b1, 8'h10, 32'h0, 4'hF, rd, lat);
    sh0 = start_hi;
    wb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, lat);
    repeat (2) @(negedge clk);
    chk("len0_no_start", start_hi - sh0, 32'd0);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    chk("len0_done", rd, 32'h6);

    // reset in the middle of a run
    wb_xfer(1'b1, 8'h10, 32'h3, 4'hF, rd, lat);
    wb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, lat);
    @(posedge clk); #1; x_tready = 1'b0;
    wb_xfer(1'b1, 8'h80, 32'd5, 4'hF, rd, lat);
    chk("mid_x_valid", {31'b0, x_tvalid}, 32'h1);
    chk("mid_x_data", x_tdata, 32'd5);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_x_valid", {31'b0, x_tvalid}, 32'h0);
    chk("rst_mid_y_tready", {31'b0, y_tready}, 32'h1);
    @(posedge clk); #1; x_tready = 1'b1;
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    chk("rst_mid_status", rd, 32'h4);
    wb_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
    chk("rst_mid_len", rd, 32'h0);
    chk("y_sb_drained", y_exp.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
